// File: rtl/bp_pht_ctrl_if.sv
// Request/response bundle between the fetch/execute stages and the pattern history table controller.
// Fetch and execute drive the master side; the table controller drives the slave side.
interface bp_pht_ctrl_if #(
  parameter int unsigned IDX_W = 6
) ();
  logic             flush;
  logic             lk_valid;
  logic [IDX_W-1:0] lk_idx;
  logic             lk_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             up_valid;
  logic [IDX_W-1:0] up_idx;
  logic             up_taken;
  logic             up_ready;
  logic             init_busy;

  modport master (
    output flush, lk_valid, lk_idx, up_valid, up_idx, up_taken,
    input  lk_ready, pred_valid, pred_taken, up_ready, init_busy
  );

  modport slave (
    input  flush, lk_valid, lk_idx, up_valid, up_idx, up_taken,
    output lk_ready, pred_valid, pred_taken, up_ready, init_busy
  );
endinterface

// File: rtl/bp_pht_ctrl.sv
// Pattern history table controller: owns an array of saturating counters, sweeps it to INIT_VAL
// after reset or flush, then serves 1-cycle lookups and single-cycle read-modify-write updates.
module bp_pht_ctrl #(
  parameter int unsigned      IDX_W    = 6,
  parameter int unsigned      CTR_W    = 2,
  parameter logic [CTR_W-1:0] INIT_VAL = CTR_W'(2'b10)
) (
  input logic            clk,
  input logic            rst,
  bp_pht_ctrl_if.slave   bus
);

  localparam int unsigned      DEPTH    = 1 << IDX_W;
  localparam logic [IDX_W-1:0] PTR_LAST = '1;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_run;
  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [CTR_W-1:0] r_tbl [DEPTH];

  logic             w_lk_acc;
  logic             w_up_acc;
  logic [CTR_W-1:0] w_up_cur;
  logic [CTR_W-1:0] w_up_nxt;

  assign w_lk_acc = bus.lk_valid & r_run;
  // An update coinciding with flush is dropped; the sweep would overwrite it anyway.
  assign w_up_acc = bus.up_valid & r_run & ~bus.flush;

  always_comb begin
    w_up_cur = r_tbl[bus.up_idx];
    w_up_nxt = w_up_cur;
    if (bus.up_taken) begin
      if (w_up_cur != '1) w_up_nxt = w_up_cur + 1'b1;
    end else begin
      if (w_up_cur != '0) w_up_nxt = w_up_cur - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_INIT;
      r_ptr        <= '0;
      r_run        <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else begin
      // Lookup reads the pre-update entry, so a same-cycle update is not bypassed.
      r_pred_valid <= w_lk_acc;
      if (w_lk_acc) r_pred_taken <= r_tbl[bus.lk_idx][CTR_W-1];

      case (r_state)
        S_INIT: begin
          if (bus.flush) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == PTR_LAST) begin
              r_state <= S_RUN;
              r_run   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
            r_run   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_INIT;
          r_ptr   <= '0;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  // Storage carries no reset; contents are defined only once the sweep has rewritten them.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_tbl[r_ptr] <= INIT_VAL;
    end else if (w_up_acc) begin
      r_tbl[bus.up_idx] <= w_up_nxt;
    end
  end

  assign bus.lk_ready   = r_run;
  assign bus.up_ready   = r_run;
  assign bus.init_busy  = ~r_run;
  assign bus.pred_valid = r_pred_valid;
  assign bus.pred_taken = r_pred_taken;

endmodule
